// File: rtl/mc_main_control_if.sv
// Control bundle between the multicycle main-control FSM and its datapath.
// master: the controller (takes opcode/zero/mem_ready, drives strobes and selects).
// slave:  the datapath side (drives opcode/zero/mem_ready, takes strobes and selects).
// Ports:  opcode[5:0], zero, mem_ready  -> controller
//         state[3:0], mem_read, mem_write, ir_write, reg_write, pc_en, iord,
//         reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//         pc_src[1:0], illegal_op       -> datapath
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic [3:0] state;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       pc_en;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output state, mem_read, mem_write, ir_write, reg_write, pc_en, iord,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  state, mem_read, mem_write, ir_write, reg_write, pc_en, iord,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
  );
endinterface

// File: rtl/mc_main_control.sv
// Multicycle MIPS main-control FSM: decodes the opcode and sequences each
// instruction over 3-5 states, driving datapath strobes and mux selects.
// Latency: R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3 cycles; +1 per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
// Backpressure: memory states hold until mem_ready; all strobes gated low while rst is high.
// Ports: clk, rst (synchronous, active-high), bus (mc_main_control_if.master).
// Optional feature: define MC_BNE_EN to decode opcode 6'b000101 (BNE) as a branch
// with inverted zero sense; otherwise that opcode is reported as illegal.
module mc_main_control (
  input  logic              clk,
  input  logic              rst,
  mc_main_control_if.master bus
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  // State encoding (visible on bus.state for debug)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  // ALU operation codes for the ALU control decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-input selects
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_SHL2 = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       branch_ne;   // 1: current branch is BNE (take on ~zero)
  logic       op_legal;    // opcode recognised by DECODE

  // Raw (pre-reset-gating) strobes
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       pc_en_raw;
  logic       illegal_raw;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch sense is captured in DECODE so a later opcode change cannot flip
  // the taken condition while in BRANCH.
`ifdef MC_BNE_EN
  logic branch_ne_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_ne_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      branch_ne_q <= (bus.opcode == OP_BNE);
    end
  end

  assign branch_ne = branch_ne_q;
`else
  assign branch_ne = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Opcode legality (only meaningful in DECODE)
  // ---------------------------------------------------------------------------
  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE:                                        op_legal = 1'b1;
`endif
      default:                                       op_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only SW leads to a write; anything else reaching here is treated as a load.
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;   // codes 12-15 recover to FETCH
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: Moore per state, with mem_ready/zero gating strobes in the
  // same cycle. Anything not assigned in a state stays 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    pc_en_raw      = 1'b0;
    illegal_raw    = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REGB;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = PCSRC_ALU;

    case (state_q)
      S_FETCH: begin
        mem_read_raw  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALU_ADD;
        // IR and PC+4 are committed only in the cycle memory delivers.
        ir_write_raw  = bus.mem_ready;
        pc_en_raw     = bus.mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target in the ALU while decoding.
        bus.alu_src_b = SRCB_SHL2;
        bus.alu_op    = ALU_ADD;
        illegal_raw   = ~op_legal;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_SEXT;
        bus.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        bus.iord      = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_REGB;
        bus.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_REGB;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = PCSRC_OUT;
        pc_en_raw     = branch_ne ? ~bus.zero : bus.zero;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_SEXT;
        bus.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        reg_write_raw  = 1'b1;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
      end
      S_JUMP: begin
        bus.pc_src = PCSRC_JUMP;
        pc_en_raw  = 1'b1;
      end
      default: begin
        // Unused encodings: everything stays 0.
      end
    endcase
  end

  // While rst is high no strobe may reach the datapath, including in the cycle
  // the reset is first applied mid-instruction.
  assign bus.mem_read   = mem_read_raw  & ~rst;
  assign bus.mem_write  = mem_write_raw & ~rst;
  assign bus.ir_write   = ir_write_raw  & ~rst;
  assign bus.reg_write  = reg_write_raw & ~rst;
  assign bus.pc_en      = pc_en_raw     & ~rst;
  assign bus.illegal_op = illegal_raw   & ~rst;
  assign bus.state      = state_q;

endmodule
